// File: rtl/bsc_pkg.sv
// Shared types and helpers for the MSB-first bit-serial magnitude comparator.
package bsc_pkg;

  localparam int BSC_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bsc_state_t;

  // Bit counter must hold the value W itself, hence W+1 distinct values.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bsc_bit_cell.sv
// One MSB-first comparison step: the first differing bit decides, later bits are ignored.
module bsc_bit_cell
  import bsc_pkg::*;
(
  input  logic xb,
  input  logic yb,
  input  logic g_in,
  input  logic l_in,
  output logic g_out,
  output logic l_out
);

  // A decision already made (g_in or l_in) blocks the opposite flag, keeping g/l exclusive.
  assign g_out = g_in | (~l_in & xb & ~yb);
  assign l_out = l_in | (~g_in & ~xb & yb);

endmodule

// File: rtl/bit_serial_comp.sv
// Bit-serial unsigned magnitude comparator with valid/ready operand and result handshakes.
// Optional macro BSC_EARLY_EXIT_EN ends the serial scan at the first differing bit.
module bit_serial_comp
  import bsc_pkg::*;
#(
  parameter int W = BSC_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         g,
  output logic         l
);

  localparam int CW = cnt_width(W);

  if (W < 1) begin : g_bad_w
    $error("bit_serial_comp: W must be >= 1");
  end

  bsc_state_t    state_q, state_d;
  logic [W-1:0]  xs_q, ys_q;
  logic [CW-1:0] cnt_q;
  logic          g_q, l_q;
  logic          cell_g, cell_l;
  logic          accept;

  bsc_bit_cell u_cell (
    .xb   (xs_q[W-1]),
    .yb   (ys_q[W-1]),
    .g_in (g_q),
    .l_in (l_q),
    .g_out(cell_g),
    .l_out(cell_l)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign g         = g_q;
  assign l         = l_q;
  assign accept    = in_valid && in_ready;

  // NOTE: state_d is assigned before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: begin
        if (cnt_q == CW'(1)) state_d = DONE;
`ifdef BSC_EARLY_EXIT_EN
        if (!g_q && !l_q && (cell_g || cell_l)) state_d = DONE;
`endif
      end
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      cnt_q   <= '0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            xs_q  <= x;
            ys_q  <= y;
            cnt_q <= CW'(W);
            g_q   <= 1'b0;
            l_q   <= 1'b0;
          end
        end
        SHIFT: begin
          g_q  <= cell_g;
          l_q  <= cell_l;
          xs_q <= xs_q << 1;
          ys_q <= ys_q << 1;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_comp.sv
// Directed bench for bit_serial_comp: vector table, handshake/backpressure/reset sequences, full sweep.
module tb_bit_serial_comp;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic         g;
  logic         l;

  int n_checks = 0;
  int n_errors = 0;

  bit_serial_comp #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .g        (g),
    .l        (l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] vx;
    logic [W-1:0] vy;
    logic         eg;
    logic         el;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Clocks from the accepting edge (counted as 1) until out_valid is seen.
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    lat = W + 1;
`ifdef BSC_EARLY_EXIT_EN
    begin
      bit found;
      found = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
        if (!found && a[i] != b[i]) begin
          lat   = W - i + 1;
          found = 1'b1;
        end
      end
    end
`endif
    return lat;
  endfunction

  // Called at posedge+1 with in_ready=1; returns at posedge+1 with out_valid=1 (or timeout).
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                input bit noise, output int lat);
    x        = a;
    y        = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    lat      = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      if (noise) begin
        check("in_ready_busy", int'(in_ready), 0);
        in_valid = 1'($urandom_range(0, 1));
        x        = W'($urandom);
        y        = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (noise) check("in_ready_done", int'(in_ready), 0);
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int lat);
    check({tag, "_latency"}, lat, exp_lat(a, b));
    check({tag, "_g"}, int'(g), int'(a > b));
    check({tag, "_l"}, int'(l), int'(a < b));
  endtask

  // With out_ready=1 the result is released on the next edge.
  task automatic finish_op(input string tag, input logic eg, input logic el);
    @(posedge clk); #1;
    check({tag, "_in_ready_back"}, int'(in_ready), 1);
    check({tag, "_out_valid_drop"}, int'(out_valid), 0);
    check({tag, "_g_kept"}, int'(g), int'(eg));
    check({tag, "_l_kept"}, int'(l), int'(el));
  endtask

  vec_t vecs[12];
  int   lat;
  int   hs;

  initial begin
    vecs[0]  = '{4'd9,  4'd6,  1'b1, 1'b0};
    vecs[1]  = '{4'd5,  4'd5,  1'b0, 1'b0};
    vecs[2]  = '{4'd8,  4'd7,  1'b1, 1'b0};
    vecs[3]  = '{4'd6,  4'd7,  1'b0, 1'b1};
    vecs[4]  = '{4'd3,  4'd12, 1'b0, 1'b1};
    vecs[5]  = '{4'd12, 4'd3,  1'b1, 1'b0};
    vecs[6]  = '{4'd1,  4'd0,  1'b1, 1'b0};
    vecs[7]  = '{4'd0,  4'd0,  1'b0, 1'b0};
    vecs[8]  = '{4'd10, 4'd11, 1'b0, 1'b1};
    vecs[9]  = '{4'd14, 4'd13, 1'b1, 1'b0};
    vecs[10] = '{4'd15, 4'd15, 1'b0, 1'b0};
    vecs[11] = '{4'd0,  4'd1,  1'b0, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    #12 rst_n = 1'b1;
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_g", int'(g), 0);
    check("reset_l", int'(l), 0);
    @(posedge clk); #1;

    // Directed table, hand-computed g/l.
    for (int i = 0; i < 12; i++) begin
      start_and_wait(vecs[i].vx, vecs[i].vy, 1'b0, lat);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].vx, vecs[i].vy));
      check($sformatf("vec%0d_g", i), int'(g), int'(vecs[i].eg));
      check($sformatf("vec%0d_l", i), int'(l), int'(vecs[i].el));
      finish_op($sformatf("vec%0d", i), vecs[i].eg, vecs[i].el);
    end

    // Back-to-back extremes with operand noise during SHIFT/DONE.
    start_and_wait(4'd0, 4'd15, 1'b1, lat);
    check_result("b2b_0_15", 4'd0, 4'd15, lat);
    finish_op("b2b_0_15", 1'b0, 1'b1);
    start_and_wait(4'd15, 4'd0, 1'b1, lat);
    check_result("b2b_15_0", 4'd15, 4'd0, lat);
    finish_op("b2b_15_0", 1'b1, 1'b0);

    // Result backpressure for 10 cycles, then exactly one handshake.
    out_ready = 1'b0;
    start_and_wait(4'd2, 4'd13, 1'b0, lat);
    check_result("bp", 4'd2, 4'd13, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_g", int'(g), 0);
      check("bp_hold_l", int'(l), 1);
      check("bp_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
    end
    check("bp_handshakes", hs, 1);
    check("bp_idle", int'(in_ready), 1);

    // Asynchronous reset during the 2nd SHIFT cycle discards the operation.
    x        = 4'd12;
    y        = 4'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_g", int'(g), 0);
    check("mid_rst_l", int'(l), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) hs++;
      @(posedge clk); #1;
    end
    check("mid_rst_no_result", hs, 0);
    start_and_wait(4'd3, 4'd12, 1'b0, lat);
    check_result("after_rst", 4'd3, 4'd12, lat);
    finish_op("after_rst", 1'b0, 1'b1);

    // Exhaustive sweep against the X>Y / X<Y reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_and_wait(W'(a), W'(b), 1'b0, lat);
        check_result($sformatf("sweep_%0d_%0d", a, b), W'(a), W'(b), lat);
        check($sformatf("sweep_%0d_%0d_excl", a, b), int'(g && l), 0);
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
